prefetch_unit: RTL

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit_pkg.sv | 17 +
 rtl/prefetch_unit_fetch_fifo.sv | 52 +++++
 rtl/prefetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared core definitions for the instruction prefetch unit: bus mode and FSM encodings.
package prefetch_unit_pkg;

  localparam int unsigned WSTRB_W = 4;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } bus_mode_t;

  typedef enum logic [1:0] {
    ST_REQ        = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_STALE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/prefetch_unit_fetch_fifo.sv
// Instruction queue: registered FIFO with flush; push and pop may coincide at any occupancy.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_data  = mem[rd_ptr];
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (rstn && !flush && do_push_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: one outstanding bus read, queued results to decode, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned fetch PC produces a faulting queue entry
// instead of a bus request, and issue stalls until the next redirect.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               request_enable,
  output logic               mode,
  output logic [XLEN-1:0]    addr,
  output logic [XLEN-1:0]    wdata,
  output logic [WSTRB_W-1:0] wstrb,
  input  logic               response_enable,
  input  logic [XLEN-1:0]    data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic               out_fault,
`endif
  output logic [XLEN-1:0]    out_instr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int unsigned EW = 2 * XLEN + 1;
`else
  localparam int unsigned EW = 2 * XLEN;
`endif

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] issue_pc_c;
  logic            req_slot_c;
  logic            issue_c;
  logic            resp_push_c;
  logic            push_c;
  logic            pop_c;
  logic [EW-1:0]   push_data_c;
  logic [EW-1:0]   pop_data;
  logic            fifo_empty;
  logic            unused_fifo_full;
  logic [CW-1:0]   fifo_count;

  // Decide whether this cycle may issue, and what the queue sees
  assign req_slot_c  = (state == ST_REQ) && !redirect_valid && (fifo_count < CW'(DEPTH));
  assign resp_push_c = (state == ST_WAIT) && response_enable && !redirect_valid;
  assign out_valid   = !fifo_empty;
  assign pop_c       = out_valid && out_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_stall;
  logic misaligned_c;
  logic trap_push_c;

  assign issue_pc_c   = fetch_pc;
  assign misaligned_c = |fetch_pc[1:0];
  assign issue_c      = req_slot_c && !trap_stall && !misaligned_c;
  assign trap_push_c  = req_slot_c && !trap_stall && misaligned_c;
  assign push_c       = resp_push_c || trap_push_c;
  assign push_data_c  = trap_push_c ? {fetch_pc, XLEN'(0), 1'b1} : {req_pc, data, 1'b0};
  assign out_pc       = pop_data[EW-1 -: XLEN];
  assign out_instr    = pop_data[XLEN:1];
  assign out_fault    = pop_data[0] && !fifo_empty;

  // Fault entry is queued once; issue then waits for a redirect
  always_ff @(posedge clk) begin
    if (!rstn || redirect_valid) trap_stall <= 1'b0;
    else if (trap_push_c)        trap_stall <= 1'b1;
  end
`else
  assign issue_pc_c  = {fetch_pc[XLEN-1:2], 2'b00};
  assign issue_c     = req_slot_c;
  assign push_c      = resp_push_c;
  assign push_data_c = {req_pc, data};
  assign out_pc      = pop_data[EW-1 -: XLEN];
  assign out_instr   = pop_data[XLEN-1:0];
`endif

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .pop_data  (pop_data),
    .full      (unused_fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch FSM with registered bus request; a redirect restarts the stream
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_REQ;
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      request_enable <= 1'b0;
      mode           <= MODE_READ;
      addr           <= '0;
      wdata          <= '0;
      wstrb          <= '0;
    end else begin
      request_enable <= 1'b0;
      mode           <= MODE_READ;
      wdata          <= '0;
      wstrb          <= '0;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        case (state)
          ST_WAIT, ST_WAIT_STALE: state <= response_enable ? ST_REQ : ST_WAIT_STALE;
          default:                state <= ST_REQ;
        endcase
      end else begin
        case (state)
          ST_REQ: begin
            if (issue_c) begin
              request_enable <= 1'b1;
              addr           <= issue_pc_c;
              req_pc         <= issue_pc_c;
              fetch_pc       <= issue_pc_c + XLEN'(4);
              state          <= ST_WAIT;
            end
          end
          ST_WAIT, ST_WAIT_STALE: begin
            if (response_enable) state <= ST_REQ;
          end
          default: state <= ST_REQ;
        endcase
      end
    end
  end

endmodule
